hd44780_read_operation: RTL and testbench
=========================================

// Module: hd44780_read_operation
// PURPOSE
// - Read-side counterpart of the HD44780 write path: runs RW=1 bus cycles on the LCD.
// - Reads the busy flag and address counter (RS=0), or a DDRAM/CGRAM byte (RS=1).
// - Poll mode repeats busy-flag reads until BF=0, so the control FSM can gate writes
//   on real LCD readiness instead of fixed delays.
// - Sits beside hd44780_write_operation; the top level muxes RS/E and tristates D from o_bus_rd.
// PARAMETERS
// - SETUP_TICKS   1    i_ena ticks from RS/RW valid to E rise (tAS)
// - E_HIGH_TICKS  2    i_ena ticks E is held high; data is sampled on the last one (tDDR)
// - HOLD_TICKS    1    i_ena ticks after E fall before RW returns to 0 (tAH, tDHR)
// - MAX_POLLS     255  busy reads attempted in poll mode before o_timeout
// PORTS
// - i_clk        in   1  system clock
// - i_reset      in   1  synchronous, active-high reset
// - i_ena        in   1  timing tick; the FSM advances only when i_ena=1
// - i_req        in   1  start request, sampled in IDLE only
// - i_sel_data   in   1  0: busy/AC read; 1: RAM data read
// - i_poll       in   1  with i_sel_data=0, repeat reads until BF=0
// - i_d          in   8  LCD data pins (input side)
// - o_rs         out  1  LCD RS
// - o_rw         out  1  LCD R/W (1 = read)
// - o_e          out  1  LCD enable
// - o_bus_rd     out  1  1 = FPGA must tristate D[7:0]
// - o_ready      out  1  1 in IDLE only
// - o_valid      out  1  one-clock pulse; o_q, o_bf and o_ac are updated on this pulse
// - o_q          out  8  last byte read
// - o_bf         out  1  busy flag (o_q[7]) of the last busy read
// - o_ac         out  7  address counter (o_q[6:0]) of the last busy read
// - o_timeout    out  1  one-clock pulse: poll gave up with BF still 1 (o_valid also pulses)
// BEHAVIOUR
// - Reset values: o_rs=0, o_rw=0, o_e=0, o_bus_rd=0, o_ready=1, o_valid=0, o_q=0,
//   o_bf=0, o_ac=0, o_timeout=0, poll count=0.
// - States: IDLE -> TURN -> SETUP -> EHI -> HOLD -> CHECK -> IDLE | SETUP.
// - IDLE: o_ready=1. On i_req=1, latch i_sel_data and i_poll, then go to TURN.
//   The latched values hold for the whole operation.
// - TURN: o_bus_rd=1, o_rw=1, o_rs=latched sel, E=0; stays 1 tick, so the FPGA
//   releases the bus before the LCD drives it.
// - SETUP: SETUP_TICKS ticks with E=0. EHI: E_HIGH_TICKS ticks with E=1.
//   i_d is captured on the last EHI tick, before E falls.
// - HOLD: E=0 for HOLD_TICKS ticks; RW and o_bus_rd stay 1.
// - CHECK (1 clock, independent of i_ena): update o_q/o_bf/o_ac and pulse o_valid.
//   - Not poll, or BF=0: go to IDLE and drop RW and o_bus_rd in the same clock.
//   - Poll, BF=1, count<MAX_POLLS-1: increment count, go to SETUP (bus stays released).
//   - Poll, BF=1, count=MAX_POLLS-1: pulse o_timeout, go to IDLE.
// - o_ac/o_bf update only on busy reads; a data read updates o_q only.
// - Poll count clears on entry to TURN, so it never wraps.
// - i_ena=0 freezes the state and tick counters. Outputs hold, including E.
// - i_req outside IDLE is ignored, not queued. i_req and i_reset in the same clock:
//   reset wins.
// - Reset mid-operation: next clock is IDLE, E=0, RW=0, o_bus_rd=0. No o_valid pulse.
// - o_bus_rd=1 exactly while RW=1, so the two can never drive the bus at once.
// STRUCTURE
// - Shared package hd44780_pkg: state encoding, RS_INSTR=0 / RS_DATA=1, BF bit index 7.
// - Sub-module hd44780_tick_counter: loadable down-counter gated by i_ena, with a
//   terminal-count flag. It is used for the SETUP, EHI and HOLD phases.
// TESTING
// - Busy read, i_ena every clock, i_d=8'h45 -> E high 2 ticks; o_valid=1 with o_bf=0,
//   o_ac=7'h45; o_ready back the next clock.
// - Poll, i_d=8'hC0 for 3 reads then 8'h12 -> 4 E pulses; one o_valid per read;
//   final o_bf=0, o_ac=7'h12; no o_timeout.
// - Poll with MAX_POLLS=4, i_d held 8'h80 -> exactly 4 E pulses, then o_timeout=1
//   and o_valid=1 in the same clock.
// - Data read, i_sel_data=1, i_d=8'h41 -> o_rs=1 throughout and o_q=8'h41;
//   o_ac/o_bf unchanged.
// - i_ena active 1 clock in 4 -> phase lengths scale by 4; a second i_req during EHI
//   is ignored.
// - i_reset asserted during EHI -> next clock E=0, RW=0, o_bus_rd=0, o_ready=1,
//   no o_valid.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared HD44780 definitions: read-FSM state encoding, RS values and bit positions.
package hd44780_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StSetup,
    StEhi,
    StHold,
    StCheck
  } rd_state_e;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  localparam int unsigned BF_BIT = 7;
  localparam int unsigned TICK_W = 8;

endpackage

// File: rtl/hd44780_read_operation_if.sv
// Request/result and LCD pin bundle for the HD44780 read engine.
interface hd44780_read_operation_if;
  logic       i_ena;
  logic       i_req;
  logic       i_sel_data;
  logic       i_poll;
  logic [7:0] i_d;
  logic       o_rs;
  logic       o_rw;
  logic       o_e;
  logic       o_bus_rd;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_q;
  logic       o_bf;
  logic [6:0] o_ac;
  logic       o_timeout;

  modport slave (
    input  i_ena, i_req, i_sel_data, i_poll, i_d,
    output o_rs, o_rw, o_e, o_bus_rd, o_ready, o_valid, o_q, o_bf, o_ac, o_timeout
  );

  modport master (
    output i_ena, i_req, i_sel_data, i_poll, i_d,
    input  o_rs, o_rw, o_e, o_bus_rd, o_ready, o_valid, o_q, o_bf, o_ac, o_timeout
  );
endinterface

// File: rtl/hd44780_tick_counter.sv
// Loadable down-counter advanced by the timing tick; o_tc flags the last tick of a phase.
module hd44780_tick_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ena,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  output logic             o_tc
);

  logic [Width-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_value;
    end else if (i_ena && !o_tc) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign o_tc = (count_q == '0);

endmodule

// File: rtl/hd44780_read_operation.sv
// HD44780 read engine: RW=1 bus cycles for busy/AC or RAM data reads, with optional
// busy-flag polling until BF clears or the poll budget runs out.
module hd44780_read_operation
  import hd44780_pkg::*;
#(
  parameter int unsigned SETUP_TICKS  = 1,
  parameter int unsigned E_HIGH_TICKS = 2,
  parameter int unsigned HOLD_TICKS   = 1,
  parameter int unsigned MAX_POLLS    = 255
) (
  input logic                       i_clk,
  input logic                       i_reset,
  hd44780_read_operation_if.slave   bus
);

  localparam int unsigned PollW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

  rd_state_e         state_q, state_d;
  logic              sel_q;
  logic              poll_q;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [7:0]        q_q;
  logic              bf_q;
  logic [6:0]        ac_q;

  logic              accept;
  logic              capture;
  logic              valid;
  logic              timeout;
  logic              cnt_load;
  logic [TICK_W-1:0] cnt_value;
  logic              cnt_tc;

  hd44780_tick_counter #(
    .Width (TICK_W)
  ) u_tick_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ena   (bus.i_ena),
    .i_load  (cnt_load),
    .i_value (cnt_value),
    .o_tc    (cnt_tc)
  );

  assign accept = (state_q == StIdle) && bus.i_req && bus.i_ena;

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    capture    = 1'b0;
    valid      = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StTurn;
          poll_cnt_d = '0;
        end
      end
      StTurn: begin
        if (bus.i_ena) begin
          state_d   = StSetup;
          cnt_load  = 1'b1;
          cnt_value = TICK_W'(SETUP_TICKS - 1);
        end
      end
      StSetup: begin
        if (bus.i_ena && cnt_tc) begin
          state_d   = StEhi;
          cnt_load  = 1'b1;
          cnt_value = TICK_W'(E_HIGH_TICKS - 1);
        end
      end
      StEhi: begin
        // Sample on the last high tick so the data is still driven as E falls.
        if (bus.i_ena && cnt_tc) begin
          capture   = 1'b1;
          state_d   = StHold;
          cnt_load  = 1'b1;
          cnt_value = TICK_W'(HOLD_TICKS - 1);
        end
      end
      StHold: begin
        if (bus.i_ena && cnt_tc) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        valid   = 1'b1;
        state_d = StIdle;
        if (poll_q && bf_q) begin
          if (poll_cnt_q == PollW'(MAX_POLLS - 1)) begin
            timeout = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + PollW'(1);
            state_d    = StSetup;
            cnt_load   = 1'b1;
            cnt_value  = TICK_W'(SETUP_TICKS - 1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      sel_q      <= RS_INSTR;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
      q_q        <= '0;
      bf_q       <= 1'b0;
      ac_q       <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      if (accept) begin
        sel_q  <= bus.i_sel_data ? RS_DATA : RS_INSTR;
        poll_q <= bus.i_poll & ~bus.i_sel_data;
      end
      if (capture) begin
        q_q <= bus.i_d;
        if (sel_q == RS_INSTR) begin
          bf_q <= bus.i_d[BF_BIT];
          ac_q <= bus.i_d[6:0];
        end
      end
    end
  end

  // RW and the tristate request are the same signal, so the FPGA never drives D while RW=1.
  assign bus.o_ready   = (state_q == StIdle);
  assign bus.o_rw      = (state_q != StIdle);
  assign bus.o_bus_rd  = (state_q != StIdle);
  assign bus.o_rs      = (state_q != StIdle) ? sel_q : RS_INSTR;
  assign bus.o_e       = (state_q == StEhi);
  assign bus.o_valid   = valid;
  assign bus.o_timeout = timeout;
  assign bus.o_q       = q_q;
  assign bus.o_bf      = bf_q;
  assign bus.o_ac      = ac_q;

endmodule

// File: tb/tb_hd44780_read_operation.sv
// Bench for hd44780_read_operation: tick-level model of the read bus cycle, checked every clock.
module tb_hd44780_read_operation;

  localparam int unsigned S  = 1;
  localparam int unsigned EH = 2;
  localparam int unsigned H  = 1;
  localparam int unsigned MP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hd44780_read_operation_if bus ();

  hd44780_read_operation #(
    .SETUP_TICKS  (S),
    .E_HIGH_TICKS (EH),
    .HOLD_TICKS   (H),
    .MAX_POLLS    (MP)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // LCD side: constant byte, or the poll script (three busy reads, then ready with AC=0x12).
  logic [7:0] d_const;
  bit         script;
  int         m_reads;
  assign bus.i_d = script ? ((m_reads < 3) ? 8'hC0 : 8'h12) : d_const;

  int ena_period = 1;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    bus.i_ena = ((cyc % ena_period) == 0);
  end

  // Model: a read is an ordered list of ena ticks (turn on the first cycle only, setup,
  // E high, hold) followed by one result clock.
  bit         m_active, m_check, m_sel, m_poll, m_first;
  int         m_tick;
  logic [7:0] m_q;
  logic       m_bf;
  logic [6:0] m_ac;

  always @(posedge clk) begin
    int pre;
    int tot;
    pre = m_first ? 1 : 0;
    tot = pre + S + EH + H;
    if (reset) begin
      m_active = 0; m_check = 0; m_sel = 0; m_poll = 0; m_first = 0;
      m_tick = 0; m_reads = 0; m_q = 8'h00; m_bf = 1'b0; m_ac = 7'h00;
    end else if (!m_active) begin
      if (bus.i_req && bus.i_ena) begin
        m_active = 1; m_check = 0; m_sel = bus.i_sel_data;
        m_poll = bus.i_poll && !bus.i_sel_data;
        m_tick = 0; m_first = 1; m_reads = 0;
      end
    end else if (m_check) begin
      if (m_poll && m_bf && (m_reads < MP - 1)) begin
        m_reads++; m_check = 0; m_tick = 0; m_first = 0;
      end else begin
        m_active = 0; m_check = 0;
      end
    end else if (bus.i_ena) begin
      if (m_tick == pre + S + EH - 1) begin
        m_q = bus.i_d;
        if (!m_sel) begin
          m_bf = bus.i_d[7];
          m_ac = bus.i_d[6:0];
        end
      end
      m_tick++;
      if (m_tick == tot) m_check = 1;
    end
  end

  int e_pulses, e_clocks, valid_cnt, to_cnt, to_with_valid;
  logic e_prev = 1'b0;

  always @(negedge clk) begin
    logic [22:0] got;
    logic [22:0] exp;
    int pre;
    logic xe, xv, xt;
    if (chk_on) begin
      pre = m_first ? 1 : 0;
      xe = m_active && !m_check && (m_tick >= pre + S) && (m_tick < pre + S + EH);
      xv = m_active && m_check;
      xt = xv && m_poll && m_bf && (m_reads == MP - 1);
      exp = {(m_active ? m_sel : 1'b0), m_active, xe, m_active, !m_active, xv, xt,
             m_q, m_bf, m_ac};
      got = {bus.o_rs, bus.o_rw, bus.o_e, bus.o_bus_rd, bus.o_ready, bus.o_valid,
             bus.o_timeout, bus.o_q, bus.o_bf, bus.o_ac};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle_compare t=%0t got {rs,rw,e,bus_rd,ready,valid,to,q,bf,ac}=%h expected %h",
                 $time, got, exp);
      end
      if (bus.o_e && !e_prev) e_pulses++;
      if (bus.o_e) e_clocks++;
      if (bus.o_valid) valid_cnt++;
      if (bus.o_timeout) to_cnt++;
      if (bus.o_timeout && bus.o_valid) to_with_valid++;
    end
    e_prev = bus.o_e;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    e_pulses = 0; e_clocks = 0; valid_cnt = 0; to_cnt = 0; to_with_valid = 0;
  endtask

  task automatic start_read(input logic sel, input logic poll);
    bit ok;
    ok = 0;
    bus.i_sel_data = sel;
    bus.i_poll = poll;
    bus.i_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!bus.o_ready) begin
        ok = 1;
        break;
      end
    end
    bus.i_req = 1'b0;
    check_lit("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.o_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    check_lit(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_e_high(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_e) begin
        ok = 1;
        break;
      end
      tick();
    end
    check_lit(name, 32'(ok), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.i_req = 1'b0;
    bus.i_sel_data = 1'b0;
    bus.i_poll = 1'b0;
    bus.i_ena = 1'b1;
    d_const = 8'h00;
    script = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    check_lit("reset_ready", 32'(bus.o_ready), 32'd1);
    check_lit("reset_rw", 32'({bus.o_rw, bus.o_bus_rd, bus.o_e, bus.o_rs}), 32'd0);
    check_lit("reset_q", 32'(bus.o_q), 32'h00);
    check_lit("reset_ac_bf", 32'({bus.o_bf, bus.o_ac}), 32'h00);
    reset = 1'b0;
    tick();

    // Busy read, tick every clock.
    d_const = 8'h45;
    clear_counts();
    start_read(1'b0, 1'b0);
    wait_ready("busy_done");
    tick();
    check_lit("busy_e_pulses", 32'(e_pulses), 32'd1);
    check_lit("busy_e_clocks", 32'(e_clocks), 32'd2);
    check_lit("busy_valid", 32'(valid_cnt), 32'd1);
    check_lit("busy_ac", 32'(bus.o_ac), 32'h45);
    check_lit("busy_bf", 32'(bus.o_bf), 32'd0);

    // Poll until BF clears on the fourth read.
    script = 1'b1;
    clear_counts();
    start_read(1'b0, 1'b1);
    wait_ready("poll_done");
    tick();
    script = 1'b0;
    check_lit("poll_e_pulses", 32'(e_pulses), 32'd4);
    check_lit("poll_valid", 32'(valid_cnt), 32'd4);
    check_lit("poll_timeout", 32'(to_cnt), 32'd0);
    check_lit("poll_ac_bf", 32'({bus.o_bf, bus.o_ac}), 32'h12);

    // Poll with BF stuck: gives up after MP reads.
    d_const = 8'h80;
    clear_counts();
    start_read(1'b0, 1'b1);
    wait_ready("timeout_done");
    tick();
    check_lit("timeout_e_pulses", 32'(e_pulses), 32'd4);
    check_lit("timeout_cnt", 32'(to_cnt), 32'd1);
    check_lit("timeout_with_valid", 32'(to_with_valid), 32'd1);
    check_lit("timeout_bf", 32'(bus.o_bf), 32'd1);

    // Data read leaves BF/AC alone.
    d_const = 8'h41;
    clear_counts();
    start_read(1'b1, 1'b0);
    wait_ready("data_done");
    tick();
    check_lit("data_q", 32'(bus.o_q), 32'h41);
    check_lit("data_ac_bf", 32'({bus.o_bf, bus.o_ac}), 32'h80);
    check_lit("data_valid", 32'(valid_cnt), 32'd1);

    // Tick one clock in four; a request during E high must be ignored.
    ena_period = 4;
    d_const = 8'h5A;
    clear_counts();
    start_read(1'b0, 1'b0);
    wait_e_high("slow_e_seen");
    bus.i_req = 1'b1;
    tick(); tick(); tick();
    bus.i_req = 1'b0;
    wait_ready("slow_done");
    for (int i = 0; i < 12; i++) tick();
    check_lit("slow_e_clocks", 32'(e_clocks), 32'd8);
    check_lit("slow_e_pulses", 32'(e_pulses), 32'd1);
    check_lit("slow_valid", 32'(valid_cnt), 32'd1);
    check_lit("slow_ac", 32'(bus.o_ac), 32'h5A);

    // Reset while E is high.
    ena_period = 1;
    d_const = 8'h33;
    clear_counts();
    start_read(1'b0, 1'b0);
    wait_e_high("rst_e_seen");
    reset = 1'b1;
    tick();
    check_lit("rst_pins", 32'({bus.o_e, bus.o_rw, bus.o_bus_rd}), 32'd0);
    check_lit("rst_ready", 32'(bus.o_ready), 32'd1);
    check_lit("rst_no_valid", 32'(valid_cnt), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check_lit("rst_ac", 32'(bus.o_ac), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
